// File: rtl/acumulador_pkg.sv
// Shared constants for the channel accumulator: mode encoding and channel-index width.
package acumulador_pkg;

  localparam logic MODE_HOLD = 1'b0;
  localparam logic MODE_SUM  = 1'b1;

  // Channel index width, never narrower than one bit (a single channel still needs a port).
  function automatic int cw_calc(input int ch);
    return (ch <= 2) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/acumulador_celda.sv
// One accumulator channel: value register, change compare, saturating adder, sticky overflow.
module acumulador_celda
  import acumulador_pkg::*;
#(
  parameter int N = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           we,
  input  logic           mode,
  input  logic [2*N-1:0] din,
  output logic [2*N-1:0] acc,
  output logic           ovf,
  output logic           changed
);

  localparam int W = 2 * N;

  logic [W-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic [W:0]   sum;
  logic [W-1:0] nxt;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, din};
    nxt     = din;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    changed = 1'b0;
    if (mode == MODE_SUM) begin
      nxt = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end
    // Clear wins over a write landing in the same cycle.
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (we) begin
      acc_d   = nxt;
      changed = (nxt != acc_q);
      if ((mode == MODE_SUM) && sum[W]) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/acumulador_canales.sv
// Multi-channel accumulator: write decode, registered change/error pulses and readout mux.
// No back-pressure: a sample presented with in_valid is always consumed on that edge.
module acumulador_canales
  import acumulador_pkg::*;
#(
  parameter  int N  = 25,
  parameter  int CH = 4,
  localparam int CW = cw_calc(CH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [CW-1:0]  in_ch,
  input  logic [2*N-1:0] In,
  input  logic           mode,
  input  logic           clear,
  input  logic [CW-1:0]  rd_ch,
  output logic [2*N-1:0] Acumulado,
  output logic           Signal,
  output logic [CW-1:0]  sig_ch,
  output logic [CH-1:0]  ovf,
  output logic           err
);

  localparam int W = 2 * N;

  logic [W-1:0]  acc_w [CH];
  logic [CH-1:0] we;
  logic [CH-1:0] changed;

  for (genvar c = 0; c < CH; c++) begin : g_celda
    assign we[c] = in_valid && !clear && (int'(in_ch) == c);

    acumulador_celda #(.N(N)) u_celda (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .we      (we[c]),
      .mode    (mode),
      .din     (In),
      .acc     (acc_w[c]),
      .ovf     (ovf[c]),
      .changed (changed[c])
    );
  end

  logic [W-1:0]  acumulado_q, acumulado_d;
  logic          signal_q, signal_d;
  logic [CW-1:0] sig_ch_q, sig_ch_d;
  logic          err_q, err_d;

  always_comb begin
    acumulado_d = '0;
    for (int c = 0; c < CH; c++) begin
      if (int'(rd_ch) == c) begin
        acumulado_d = acc_w[c];
      end
    end
    signal_d = |changed;
    sig_ch_d = sig_ch_q;
    if (|changed) begin
      sig_ch_d = in_ch;
    end
    err_d = in_valid && !clear && (int'(in_ch) >= CH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acumulado_q <= '0;
      signal_q    <= 1'b0;
      sig_ch_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      acumulado_q <= acumulado_d;
      signal_q    <= signal_d;
      sig_ch_q    <= sig_ch_d;
      err_q       <= err_d;
    end
  end

  assign Acumulado = acumulado_q;
  assign Signal    = signal_q;
  assign sig_ch    = sig_ch_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acumulador_canales.sv
// Bench for acumulador_canales with N=4, CH=3: directed scenarios plus random streams vs a reference model.
module tb_acumulador_canales;

  localparam int N   = 4;
  localparam int CH  = 3;
  localparam int CW  = 2;
  localparam int W   = 2 * N;
  localparam int MAX = (1 << W) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_ch;
  logic [W-1:0]  in_data;
  logic          mode;
  logic          clear;
  logic [CW-1:0] rd_ch;
  logic [W-1:0]  acumulado;
  logic          signal;
  logic [CW-1:0] sig_ch;
  logic [CH-1:0] ovf;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: channel values, sticky flags, last reported channel.
  int m_acc [CH];
  bit m_ovf [CH];
  int m_sig_ch;

  acumulador_canales #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .In        (in_data),
    .mode      (mode),
    .clear     (clear),
    .rd_ch     (rd_ch),
    .Acumulado (acumulado),
    .Signal    (signal),
    .sig_ch    (sig_ch),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
    m_sig_ch = 0;
  endtask

  function automatic logic [CH-1:0] exp_ovf();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_ovf[c];
    return v;
  endfunction

  // Apply one cycle of inputs, advance the model, check all outputs just after the edge.
  task automatic drive_cycle(input bit v, input int ch, input int data, input bit md,
                             input bit clr, input int rch);
    int e_acum;
    int nxt;
    bit e_sig;
    bit e_err;
    logic [31:0] ch_l, d_l, r_l;
    ch_l = ch; d_l = data; r_l = rch;
    in_valid = v;
    in_ch    = ch_l[CW-1:0];
    in_data  = d_l[W-1:0];
    mode     = md;
    clear    = clr;
    rd_ch    = r_l[CW-1:0];
    e_acum = (rch < CH) ? m_acc[rch] : 0;
    e_sig  = 1'b0;
    e_err  = 1'b0;
    if (clr) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0;
        m_ovf[c] = 1'b0;
      end
    end else if (v && ch >= CH) begin
      e_err = 1'b1;
    end else if (v) begin
      if (md) begin
        nxt = m_acc[ch] + data;
        if (nxt > MAX) begin
          nxt = MAX;
          m_ovf[ch] = 1'b1;
        end
      end else begin
        nxt = data;
      end
      if (nxt != m_acc[ch]) begin
        e_sig    = 1'b1;
        m_sig_ch = ch;
      end
      m_acc[ch] = nxt;
    end
    @(posedge clk);
    #1;
    check_eq("acumulado", acumulado, e_acum);
    check_eq("signal", signal, e_sig);
    check_eq("sig_ch", sig_ch, m_sig_ch);
    check_eq("err", err, e_err);
    check_eq("ovf", ovf, exp_ovf());
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_acumulado"}, acumulado, 0);
    check_eq({tag, "_signal"}, signal, 0);
    check_eq({tag, "_sig_ch"}, sig_ch, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ch    = '0;
    in_data  = '0;
    mode     = 1'b0;
    clear    = 1'b0;
    rd_ch    = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // HOLD: same value twice on ch1, then read it back.
    drive_cycle(1, 1, 8'h3C, 0, 0, 1);
    drive_cycle(1, 1, 8'h3C, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    check_eq("hold_readback", acumulado, 8'h3C);

    // SUM: saturation on ch2, then a write that cannot change the value.
    drive_cycle(1, 2, 8'hF0, 1, 0, 2);
    drive_cycle(1, 2, 8'h20, 1, 0, 2);
    drive_cycle(1, 2, 8'h01, 1, 0, 2);
    drive_cycle(0, 0, 0, 1, 0, 2);
    check_eq("sum_saturated", acumulado, 8'hFF);
    check_eq("sum_ovf2", ovf[2], 1'b1);
    drive_cycle(1, 2, 8'h00, 1, 0, 2);

    // Mode change preserves contents; zero add in SUM makes no pulse.
    drive_cycle(1, 1, 8'h00, 1, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 2);

    // Clear wins over a simultaneous write.
    drive_cycle(1, 0, 8'h11, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 2);

    // Out-of-range channel.
    drive_cycle(1, 0, 8'h55, 0, 0, 0);
    drive_cycle(1, 3, 8'h77, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(1, 3, 8'h77, 1, 0, 1);

    // SUM stream on ch0 interrupted by an asynchronous reset between edges.
    for (int i = 0; i < 6; i++) drive_cycle(1, 0, $urandom_range(1, 80), 1, 0, 0);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive_cycle(1, 0, $urandom_range(1, 80), 1, 0, 0);
    drive_cycle(0, 0, 0, 1, 0, 0);

    // Round-robin HOLD stream, small data range so repeats occur.
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1, i % CH, $urandom_range(0, 3), 0, 0, $urandom_range(0, CH - 1));
    end

    // Mixed random traffic including invalid channels, idles and occasional clears.
    for (int i = 0; i < 300; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, MAX);
      drive_cycle($urandom_range(0, 4) != 0, $urandom_range(0, 3), d,
                  $urandom_range(0, 1), $urandom_range(0, 24) == 0, $urandom_range(0, CH - 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acumulador_canales.md
ACUMULADOR_CANALES -- requirements
Module: acumulador_canales

Interface
REQ-001 Parameter N, default 25, sample half-width; data path width SHALL be 2*N bits.
REQ-002 Parameter CH, default 4, channel count (1..16); CW = max(1, clog2(CH)) SHALL size channel indices.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  sample strobe for channel in_ch.
REQ-006 in_ch  input  CW  target channel of the sample.
REQ-007 In  input  2N  sample value, unsigned.
REQ-008 mode  input  1  0 = HOLD (store on change), 1 = SUM (saturating accumulate).
REQ-009 clear  input  1  synchronous clear of all channels.
REQ-010 rd_ch  input  CW  readout channel select.
REQ-011 Acumulado  output  2N  registered value of channel rd_ch.
REQ-012 Signal  output  1  one-cycle pulse: a channel value changed.
REQ-013 sig_ch  output  CW  channel that caused the current Signal pulse.
REQ-014 ovf  output  CH  sticky per-channel saturation flags.
REQ-015 err  output  1  one-cycle pulse: in_valid with in_ch >= CH.

Function
REQ-016 Each channel SHALL hold one 2N-bit register acc[c]; only channel in_ch SHALL be updated per cycle.
REQ-017 HOLD, in_valid, In != acc[in_ch]: acc <= In, Signal = 1 and sig_ch = in_ch in the next cycle.
REQ-018 HOLD, in_valid, In == acc[in_ch]: acc unchanged, Signal = 0.
REQ-019 SUM, in_valid: acc <= min(acc + In, 2^(2N)-1), sum computed 2N+1 bits wide.
REQ-020 SUM: Signal SHALL pulse only when the stored value actually changes (In = 0 or acc already at max -> no pulse).
REQ-021 SUM: ovf[in_ch] SHALL set when acc + In > 2^(2N)-1 and SHALL remain set until clear or reset.
REQ-022 Signal, sig_ch and err SHALL have one-cycle latency from the in_valid edge and SHALL deassert the following cycle absent a new event; sig_ch SHALL hold its last value when Signal = 0.
REQ-023 in_valid with in_ch >= CH: no state change, Signal = 0, err = 1 next cycle.
REQ-024 clear SHALL zero all acc and ovf on the next edge and SHALL take priority over a simultaneous in_valid (no Signal, no err).
REQ-025 mode SHALL be sampled per in_valid; changing mode SHALL preserve acc and ovf contents.
REQ-026 Acumulado SHALL equal acc[rd_ch] as of the previous edge, registered (one-cycle read latency); a write and read to the same channel in one cycle SHALL show the new value one cycle after the write lands.
REQ-027 Back-to-back in_valid every cycle SHALL be accepted without stall; no handshake back-pressure exists.

Reset
REQ-028 rst_n low SHALL asynchronously force acc = 0, ovf = 0, Acumulado = 0, Signal = 0, sig_ch = 0, err = 0.
REQ-029 Reset asserted mid-accumulation SHALL discard the in-flight sample; first update after release SHALL occur on the first rising edge with rst_n high.

Structure
REQ-030 Shared package acumulador_pkg SHALL hold MODE_HOLD/MODE_SUM constants and the CW width computation.
REQ-031 One sub-module acumulador_celda (per-channel register, compare, saturating adder, ovf) SHALL be instantiated CH times; top holds decode, event flags and readout mux.

Verification
REQ-032 N=4, HOLD: write ch1 = 0x3C twice -> Signal=1, sig_ch=1 after first; Signal=0 after second; Acumulado(rd_ch=1)=0x3C.
REQ-033 N=4, SUM: ch2 writes 0xF0 then 0x20 -> acc=0xFF, ovf[2]=1, Signal pulses twice; third write 0x01 -> no Signal.
REQ-034 clear and in_valid (ch0, 0x11) same cycle -> acc[0]=0, ovf=0, Signal=0.
REQ-035 CH=3: in_valid with in_ch=3 -> err=1 one cycle, all acc unchanged, Signal=0.
REQ-036 rst_n pulsed low between clock edges during SUM stream -> all outputs 0 immediately; stream resumes from 0 after release.
REQ-037 Continuous in_valid round-robin over all channels, HOLD, random data -> every change produces exactly one Signal with correct sig_ch; scoreboard matches acc.
